bus_copy_master: RTL and testbench

BUS_COPY_MASTER -- requirements
Module: bus_copy_master

---
 rtl/bus_copy_master_if.sv | 27 ++
 rtl/bus_copy_master.sv | 97 +++++++++
 tb/tb_bus_copy_master.sv | 337 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bus_copy_master_if.sv
// Control and bus signals shared between bus_copy_master and its slave/requester.
// The master modport is the copy engine's view; slave is the bus/requester side.
interface bus_copy_master_if #(
  parameter int LEN_W = 16
);
  logic             start;
  logic [31:0]      srcAddr;
  logic [31:0]      dstAddr;
  logic [LEN_W-1:0] len;
  logic             busy;
  logic             done;
  logic             bSel;
  logic             bWrite;
  logic [31:0]      bAddr;
  logic [31:0]      bWData;
  logic [31:0]      bRData;

  modport master (
    input  start, srcAddr, dstAddr, len, bRData,
    output busy, done, bSel, bWrite, bAddr, bWData
  );

  modport slave (
    output start, srcAddr, dstAddr, len, bRData,
    input  busy, done, bSel, bWrite, bAddr, bWData
  );
endinterface

// File: rtl/bus_copy_master.sv
// Word-copy bus master: reads len words from srcAddr and writes them to dstAddr, one RD then one WR per word.
// Define BUS_COPY_FILL_EN to build the fill variant: no reads, every word written with FILL_WORD.
module bus_copy_master #(
  parameter int          LEN_W     = 16,
  parameter logic [31:0] FILL_WORD = 32'h0000_0000
) (
  input logic               clk,
  input logic               rst,
  bus_copy_master_if.master bus
);

  typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

`ifdef BUS_COPY_FILL_EN
  localparam state_t WORD_START = WR;
`else
  localparam state_t WORD_START = RD;
`endif

  state_t           state;
  state_t           stateNext;
  logic [31:0]      srcReg;
  logic [31:0]      dstReg;
  logic [31:0]      dataReg;
  logic [LEN_W-1:0] remReg;

  // NOTE: every output and stateNext gets a default first, so no path leaves one unassigned (no latch).
  always_comb begin
    stateNext  = state;
    bus.busy   = 1'b0;
    bus.done   = 1'b0;
    bus.bSel   = 1'b0;
    bus.bWrite = 1'b0;
    bus.bAddr  = 32'h0;
    bus.bWData = 32'h0;
    unique case (state)
      IDLE: begin
        if (bus.start) stateNext = (bus.len != '0) ? WORD_START : DONE;
      end
      RD: begin
        bus.busy  = 1'b1;
        bus.bSel  = 1'b1;
        bus.bAddr = srcReg;
        stateNext = WR;
      end
      WR: begin
        bus.busy   = 1'b1;
        bus.bSel   = 1'b1;
        bus.bWrite = 1'b1;
        bus.bAddr  = dstReg;
`ifdef BUS_COPY_FILL_EN
        bus.bWData = FILL_WORD;
`else
        bus.bWData = dataReg;
`endif
        // remReg is still the pre-decrement count here: 1 means this is the last word.
        stateNext = (remReg == LEN_W'(1)) ? DONE : WORD_START;
      end
      DONE: begin
        bus.done  = 1'b1;
        stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      srcReg  <= 32'h0;
      dstReg  <= 32'h0;
      dataReg <= 32'h0;
      remReg  <= '0;
    end else begin
      state <= stateNext;
      unique case (state)
        IDLE: begin
          if (bus.start && (bus.len != '0)) begin
            srcReg <= bus.srcAddr;
            dstReg <= bus.dstAddr;
            remReg <= bus.len;
          end
        end
        RD: dataReg <= bus.bRData;
        WR: begin
          // Address wrap past 32'hFFFF_FFFC is the intended modulo-2^32 behaviour.
          srcReg <= srcReg + 32'd4;
          dstReg <= dstReg + 32'd4;
          remReg <= remReg - LEN_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_copy_master.sv
// Self-checking bench for bus_copy_master: scoreboard of expected bus cycles plus a small gpio/memory slave.
`timescale 1ns/1ps
module tb_bus_copy_master;

  localparam int          LEN_W = 16;
  localparam logic [31:0] FILL  = 32'h0000_AAAA;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
    int          off;
  } busTxn_t;

  logic        clk = 1'b0;
  logic        rst;
  int          nRun = 0;
  int          nFail = 0;
  busTxn_t     expQ[$];
  logic [31:0] mem    [256];
  logic [31:0] refMem [256];
  logic [15:0] gpioIn;
  logic [15:0] gpioOut;
  logic [15:0] refGpioOut;

  bus_copy_master_if #(.LEN_W(LEN_W)) bus ();

  bus_copy_master #(.LEN_W(LEN_W), .FILL_WORD(FILL)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Slave: address 0 reads the gpio input, address 4 drives the gpio output, the rest is a 256-word memory.
  always_comb bus.bRData = (bus.bAddr == 32'h0) ? {16'h0, gpioIn} : mem[bus.bAddr[9:2]];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  function automatic logic [31:0] modelRead(input logic [31:0] a);
    return (a == 32'h0) ? {16'h0, gpioIn} : refMem[a[9:2]];
  endfunction

  task automatic modelWrite(input logic [31:0] a, input logic [31:0] d);
    if (a == 32'h4) refGpioOut = d[15:0];
    else            refMem[a[9:2]] = d;
  endtask

  task automatic setWord(input logic [31:0] a, input logic [31:0] d);
    mem[a[9:2]]    = d;
    refMem[a[9:2]] = d;
  endtask

  // Starts one transfer and samples every cycle at negedge. restartAt/rstAt (-1 = unused) give the
  // cycle offset whose ending edge sees a second start pulse or a reset.
  task automatic runTransfer(input string name, input logic [31:0] src, input logic [31:0] dst,
                             input int n, input int restartAt, input int rstAt);
    busTxn_t e;
    int      expDone;
    int      lastOff;
    int      doneCnt = 0;
    int      doneOff = -1;
    int      busyCnt = 0;
    int      memBad  = 0;
    logic [31:0] rdData;
`ifdef BUS_COPY_FILL_EN
    expDone = (n == 0) ? 1 : n + 1;
    for (int i = 0; i < n; i++) begin
      if (rstAt < 0 || i + 1 <= rstAt) begin
        e = '{wr: 1'b1, addr: dst + 32'(4 * i), data: FILL, off: i + 1};
        expQ.push_back(e);
        modelWrite(e.addr, e.data);
      end
    end
`else
    expDone = (n == 0) ? 1 : 2 * n + 1;
    for (int i = 0; i < n; i++) begin
      rdData = modelRead(src + 32'(4 * i));
      if (rstAt < 0 || 1 + 2 * i <= rstAt) begin
        e = '{wr: 1'b0, addr: src + 32'(4 * i), data: rdData, off: 1 + 2 * i};
        expQ.push_back(e);
      end
      if (rstAt < 0 || 2 + 2 * i <= rstAt) begin
        e = '{wr: 1'b1, addr: dst + 32'(4 * i), data: rdData, off: 2 + 2 * i};
        expQ.push_back(e);
        modelWrite(e.addr, e.data);
      end
    end
`endif
    lastOff = (rstAt >= 0) ? rstAt + 3 : expDone + 1;

    bus.start   = 1'b1;
    bus.srcAddr = src;
    bus.dstAddr = dst;
    bus.len     = LEN_W'(n);
    for (int off = 1; off <= lastOff; off++) begin
      @(negedge clk);
      if (bus.bSel === 1'b1) begin
        nRun++;
        if (expQ.size() == 0) begin
          nFail++;
          $display("FAIL %s unexpected bus cycle: off=%0d wr=%b addr=%h", name, off, bus.bWrite, bus.bAddr);
        end else begin
          e = expQ.pop_front();
          if (bus.bWrite !== e.wr || bus.bAddr !== e.addr || off !== e.off ||
              (e.wr && bus.bWData !== e.data)) begin
            nFail++;
            $display("FAIL %s bus cycle: got off=%0d wr=%b addr=%h wdata=%h, expected off=%0d wr=%b addr=%h wdata=%h",
                     name, off, bus.bWrite, bus.bAddr, bus.bWData, e.off, e.wr, e.addr, e.data);
          end
        end
        if (bus.bWrite === 1'b1) begin
          if (bus.bAddr == 32'h4) gpioOut = bus.bWData[15:0];
          else                    mem[bus.bAddr[9:2]] = bus.bWData;
        end
      end else begin
        nRun++;
        if (bus.bSel !== 1'b0 || bus.bWrite !== 1'b0 || bus.bAddr !== 32'h0 || bus.bWData !== 32'h0) begin
          nFail++;
          $display("FAIL %s idle bus: off=%0d sel=%b wr=%b addr=%h wdata=%h, expected all zero",
                   name, off, bus.bSel, bus.bWrite, bus.bAddr, bus.bWData);
        end
      end
      nRun++;
      if (bus.busy !== bus.bSel) begin
        nFail++;
        $display("FAIL %s busy: off=%0d busy=%b, expected %b", name, off, bus.busy, bus.bSel);
      end
      if (bus.busy === 1'b1) busyCnt++;
      if (bus.done === 1'b1) begin
        doneCnt++;
        doneOff = off;
      end
      // Inputs for the edge ending this cycle; addresses/len are scrambled to show they are not re-read.
      bus.start = (off == restartAt);
      if (off == restartAt) begin
        bus.srcAddr = 32'h0000_0300;
        bus.dstAddr = 32'h0000_0380;
        bus.len     = LEN_W'(5);
      end else begin
        bus.srcAddr = $urandom;
        bus.dstAddr = $urandom;
        bus.len     = LEN_W'($urandom);
      end
      rst = (off == rstAt);
    end
    bus.start = 1'b0;
    rst       = 1'b0;

    nRun++;
    if (expQ.size() != 0) begin
      nFail++;
      $display("FAIL %s missing bus cycles: %0d left, expected 0", name, expQ.size());
    end
    expQ.delete();
    nRun++;
    if (doneCnt != ((rstAt >= 0) ? 0 : 1)) begin
      nFail++;
      $display("FAIL %s done pulses: got %0d, expected %0d", name, doneCnt, (rstAt >= 0) ? 0 : 1);
    end
    if (rstAt < 0) begin
      nRun++;
      if (doneOff != expDone) begin
        nFail++;
        $display("FAIL %s done latency: got k+%0d, expected k+%0d", name, doneOff, expDone);
      end
      nRun++;
`ifdef BUS_COPY_FILL_EN
      if (busyCnt != n) begin
        nFail++;
        $display("FAIL %s busy cycles: got %0d, expected %0d", name, busyCnt, n);
      end
`else
      if (busyCnt != 2 * n) begin
        nFail++;
        $display("FAIL %s busy cycles: got %0d, expected %0d", name, busyCnt, 2 * n);
      end
`endif
    end
    for (int i = 0; i < 256; i++) if (mem[i] !== refMem[i]) memBad++;
    nRun++;
    if (memBad != 0 || gpioOut !== refGpioOut) begin
      nFail++;
      $display("FAIL %s memory image: %0d bad words, gpioOut=%h, expected 0 bad words, gpioOut=%h",
               name, memBad, gpioOut, refGpioOut);
    end
  endtask

  task automatic test_reset();
    rst         = 1'b1;
    bus.start   = 1'b1;
    bus.srcAddr = 32'h100;
    bus.dstAddr = 32'h200;
    bus.len     = LEN_W'(2);
    repeat (2) @(negedge clk);
    nRun++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.bSel !== 1'b0 || bus.bWrite !== 1'b0 ||
        bus.bAddr !== 32'h0 || bus.bWData !== 32'h0) begin
      nFail++;
      $display("FAIL reset outputs: busy=%b done=%b sel=%b wr=%b addr=%h wdata=%h, expected all zero",
               bus.busy, bus.done, bus.bSel, bus.bWrite, bus.bAddr, bus.bWData);
    end
    rst       = 1'b0;
    bus.start = 1'b0;
    @(negedge clk);
    nRun++;
    if (bus.bSel !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      nFail++;
      $display("FAIL reset dominates start: sel=%b busy=%b done=%b, expected 0 0 0", bus.bSel, bus.busy, bus.done);
    end
  endtask

  task automatic test_gpio();
`ifdef BUS_COPY_FILL_EN
    runTransfer("fill_gpio", 32'h0, 32'h4, 1, -1, -1);
    nRun++;
    if (gpioOut !== 16'hAAAA) begin
      nFail++;
      $display("FAIL fill_gpio output: got %h, expected aaaa", gpioOut);
    end
`else
    gpioIn = 16'h55AA;
    runTransfer("copy_gpio", 32'h0, 32'h4, 1, -1, -1);
    nRun++;
    if (gpioOut !== 16'h55AA) begin
      nFail++;
      $display("FAIL copy_gpio output: got %h, expected 55aa", gpioOut);
    end
`endif
  endtask

  task automatic test_mem_copy();
    setWord(32'h100, 32'h11);
    setWord(32'h104, 32'h22);
    setWord(32'h108, 32'h33);
    runTransfer("mem_copy", 32'h100, 32'h200, 3, -1, -1);
`ifndef BUS_COPY_FILL_EN
    nRun++;
    if (mem[8'h80] !== 32'h11 || mem[8'h81] !== 32'h22 || mem[8'h82] !== 32'h33) begin
      nFail++;
      $display("FAIL mem_copy dst words: got %h %h %h, expected 11 22 33", mem[8'h80], mem[8'h81], mem[8'h82]);
    end
`endif
  endtask

  task automatic test_len_zero();
    runTransfer("len_zero", 32'h100, 32'h240, 0, -1, -1);
  endtask

  task automatic test_abort();
    setWord(32'h120, 32'hA1);
    setWord(32'h124, 32'hA2);
    setWord(32'h128, 32'hA3);
    setWord(32'h220, 32'h0);
    setWord(32'h224, 32'h0);
    setWord(32'h228, 32'h0);
`ifdef BUS_COPY_FILL_EN
    runTransfer("abort", 32'h120, 32'h220, 3, -1, 1);
`else
    // Reset edge lands where the second WR would begin, so word 0 is written and word 1 is not.
    runTransfer("abort", 32'h120, 32'h220, 3, -1, 3);
    nRun++;
    if (mem[8'h88] !== 32'hA1 || mem[8'h89] !== 32'h0) begin
      nFail++;
      $display("FAIL abort partial copy: got %h %h, expected a1 0", mem[8'h88], mem[8'h89]);
    end
`endif
    runTransfer("after_abort", 32'h120, 32'h220, 3, -1, -1);
  endtask

  task automatic test_restart_wrap();
    setWord(32'hFFFF_FFFC, 32'hDEAD_BEEF);
    gpioIn = 16'h1234;
    runTransfer("restart_wrap", 32'hFFFF_FFFC, 32'h40, 2, 2, -1);
`ifndef BUS_COPY_FILL_EN
    nRun++;
    if (mem[8'h10] !== 32'hDEAD_BEEF || mem[8'h11] !== 32'h0000_1234) begin
      nFail++;
      $display("FAIL restart_wrap dst words: got %h %h, expected deadbeef 00001234", mem[8'h10], mem[8'h11]);
    end
`endif
  endtask

  task automatic test_overlap();
    setWord(32'h180, 32'h1);
    setWord(32'h184, 32'h2);
    setWord(32'h188, 32'h3);
    setWord(32'h18C, 32'h4);
    runTransfer("overlap", 32'h180, 32'h184, 3, -1, -1);
`ifndef BUS_COPY_FILL_EN
    nRun++;
    if (mem[8'h61] !== 32'h1 || mem[8'h62] !== 32'h1 || mem[8'h63] !== 32'h1) begin
      nFail++;
      $display("FAIL overlap ascending copy: got %h %h %h, expected 1 1 1", mem[8'h61], mem[8'h62], mem[8'h63]);
    end
`endif
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) begin
      setWord(32'h2C0 + 32'(4 * i), $urandom);
    end
    runTransfer("b2b_a", 32'h2C0, 32'h340, 4, -1, -1);
    runTransfer("b2b_b", 32'h340, 32'h2E0, 2, -1, -1);
  endtask

  initial begin
    gpioIn      = 16'h0;
    gpioOut     = 16'h0;
    refGpioOut  = 16'h0;
    bus.start   = 1'b0;
    bus.srcAddr = 32'h0;
    bus.dstAddr = 32'h0;
    bus.len     = '0;
    rst         = 1'b1;
    for (int i = 0; i < 256; i++) begin
      mem[i]    = 32'h0;
      refMem[i] = 32'h0;
    end
    test_reset();
    test_gpio();
    test_mem_copy();
    test_len_zero();
    test_abort();
    test_restart_wrap();
    test_overlap();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", nRun, nFail);
    $finish;
  end

endmodule
